// File: rtl/inst_prefetch_queue_if.sv
// Bundle between the prefetch queue, the instruction memory, the redirect
// source and the IF/ID register. master = queue side, slave = environment side.
interface inst_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_inst, count,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_inst, count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch into a DEPTH-entry
// {pc, inst} FIFO with redirect flush. Define PFQ_BYPASS_EN for the empty-FIFO bypass.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_prefetch_queue_if.master bus
);
  localparam int              AW        = $clog2(DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [CW:0]     DEPTH_EXT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   req_pc_reg, req_pc_next;
  logic          inflight_reg, inflight_next;
  logic          squash_reg, squash_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic [31:0]   fifo_pc_mem   [DEPTH];
  logic [31:0]   fifo_inst_mem [DEPTH];

  logic          issue;
  logic          head_valid;
  logic          return_valid;
  logic          byp_take;
  logic          push_en;
  logic          pop_en;
  logic          out_valid_int;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;

  wire unused_rpc_lo = &{1'b0, bus.redirect_pc[1:0]};

  assign head_pc   = fifo_pc_mem[rd_ptr_reg[AW-1:0]];
  assign head_inst = fifo_inst_mem[rd_ptr_reg[AW-1:0]];

  // Datapath control: credit check counts the word already in flight so the
  // FIFO can never be asked to take more than DEPTH entries.
  always_comb begin
    head_valid   = (count_reg != '0);
    issue        = rst && !bus.redirect_valid &&
                   (({1'b0, count_reg} + (CW+1)'(inflight_reg)) < DEPTH_EXT);
    return_valid = inflight_reg && !squash_reg && !bus.redirect_valid;
`ifdef PFQ_BYPASS_EN
    byp_take     = return_valid && !head_valid;
`else
    byp_take     = 1'b0;
`endif
    out_valid_int = !bus.redirect_valid && (head_valid || byp_take);
    pop_en        = head_valid && bus.out_ready && !bus.redirect_valid;
    push_en       = return_valid && !(byp_take && bus.out_ready);
  end

  always_comb begin
    bus.imem_req  = issue;
    bus.imem_addr = fetch_pc_reg;
    bus.out_valid = out_valid_int;
    bus.count     = count_reg;
    bus.out_pc    = 32'h0;
    bus.out_inst  = NOP;
    if (out_valid_int) begin
      if (head_valid) begin
        bus.out_pc   = head_pc;
        bus.out_inst = head_inst;
      end else begin
        bus.out_pc   = req_pc_reg;
        bus.out_inst = bus.imem_rdata;
      end
    end
  end

  // Next-state: redirect overrides every push, pop and issue in its cycle.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    inflight_next = issue;
    squash_next   = 1'b0;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    if (bus.redirect_valid) begin
      fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
      squash_next   = inflight_reg;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (issue) begin
        req_pc_next   = fetch_pc_reg;
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      wr_ptr_next = wr_ptr_reg + CW'(push_en);
      rd_ptr_next = rd_ptr_reg + CW'(pop_en);
      count_next  = count_reg + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      inflight_reg <= 1'b0;
      squash_reg   <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      inflight_reg <= inflight_next;
      squash_reg   <= squash_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_pc_mem[wr_ptr_reg[AW-1:0]]   <= req_pc_reg;
      fifo_inst_mem[wr_ptr_reg[AW-1:0]] <= bus.imem_rdata;
    end
  end

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(push_en && !pop_en && count_reg == DEPTH_CNT));

  ptr_consistent_a: assert property (@(posedge clk) disable iff (!rst)
    count_reg == (wr_ptr_reg - rd_ptr_reg));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: table of per-cycle vectors plus
// hand-written reset and steady-stream sequences; honours PFQ_BYPASS_EN.
module tb_inst_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef PFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .NOP      (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous instruction memory: word at byte address A holds 0x100 + A.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= 32'h100 + bus.imem_addr;
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [30];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [31:0] pc,
                               input logic [2:0] cnt, input logic req, input logic [31:0] addr);
    logic [31:0] exp_inst;
    exp_inst = v ? (32'h100 + pc) : NOP;
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".out_pc"},    bus.out_pc,         pc);
    check({tag, ".out_inst"},  bus.out_inst,       exp_inst);
    check({tag, ".count"},     32'(bus.count),     32'(cnt));
    check({tag, ".imem_req"},  32'(bus.imem_req),  32'(req));
    check({tag, ".imem_addr"}, bus.imem_addr,      addr);
  endtask

  task automatic apply_row(input int i);
    bus.out_ready      = vecs[i].ready;
    bus.redirect_valid = vecs[i].redir;
    bus.redirect_pc    = vecs[i].rpc;
    #1;
    check_outputs($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].cnt,
                  vecs[i].req, vecs[i].addr);
    $display("vec %0d: ready=%0b redir=%0b valid=%0b pc=%h inst=%h count=%0d req=%0b addr=%h",
             i, bus.out_ready, bus.redirect_valid, bus.out_valid, bus.out_pc,
             bus.out_inst, bus.count, bus.imem_req, bus.imem_addr);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    logic [31:0] exp_pc;
    logic        exp_v;

    // Row 0 is the first cycle after reset release; fill to DEPTH, drain,
    // redirect with pop (misaligned 0x43), then redirect near the top of memory.
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         BYP,  32'h0,         3'd0, 1'b1, 32'h4};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         3'd1, 1'b1, 32'h8};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         3'd2, 1'b1, 32'hC};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         3'd3, 1'b0, 32'h10};
    for (int i = 5; i <= 11; i++)
      vecs[i] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,         3'd4, 1'b0, 32'h10};
    vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         3'd4, 1'b0, 32'h10};
    vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         3'd3, 1'b1, 32'h10};
    vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         3'd2, 1'b1, 32'h14};
    vecs[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         3'd2, 1'b1, 32'h18};
    vecs[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h10,        3'd2, 1'b1, 32'h1C};
    vecs[17] = '{1'b1, 1'b1, 32'h43,        1'b0, 32'h0,         3'd2, 1'b0, 32'h20};
    vecs[18] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0, 1'b1, 32'h40};
    vecs[19] = '{1'b0, 1'b0, 32'h0,         BYP,  BYP ? 32'h40 : 32'h0, 3'd0, 1'b1, 32'h44};
    vecs[20] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h40,        3'd1, 1'b1, 32'h48};
    vecs[21] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        3'd2, 1'b1, 32'h4C};
    vecs[22] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h44,        3'd2, 1'b1, 32'h50};
    vecs[23] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         3'd2, 1'b0, 32'h54};
    vecs[24] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0, 1'b1, 32'hFFFF_FFF8};
    vecs[25] = '{1'b0, 1'b0, 32'h0,         BYP,  BYP ? 32'hFFFF_FFF8 : 32'h0, 3'd0, 1'b1, 32'hFFFF_FFFC};
    vecs[26] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 3'd1, 1'b1, 32'h0};
    vecs[27] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 3'd2, 1'b1, 32'h4};
    vecs[28] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 3'd2, 1'b1, 32'h8};
    vecs[29] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         3'd2, 1'b1, 32'hC};

    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst                = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    $display("reset: valid=%0b inst=%h count=%0d req=%0b", bus.out_valid, bus.out_inst,
             bus.count, bus.imem_req);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 30; i++) apply_row(i);

    // Let the FIFO accumulate three entries, then pull reset asynchronously.
    bus.out_ready = 1'b0;
    #1;
    check("prefill.count2", 32'(bus.count), 32'd2);
    @(negedge clk);
    #1;
    check("prefill.count3", 32'(bus.count), 32'd3);
    $display("prefill: count=%0d head_pc=%h", bus.count, bus.out_pc);
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    $display("async_rst: valid=%0b inst=%h count=%0d req=%0b addr=%h", bus.out_valid,
             bus.out_inst, bus.count, bus.imem_req, bus.imem_addr);

    // Restart from RESET_PC with out_ready held high: one word per cycle.
    @(negedge clk);
    @(negedge clk);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    first = BYP ? 1 : 2;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_v  = (k >= first);
      exp_pc = exp_v ? 32'((k - first) * 4) : 32'h0;
      check($sformatf("stream%0d.out_valid", k), 32'(bus.out_valid), 32'(exp_v));
      check($sformatf("stream%0d.out_pc", k), bus.out_pc, exp_pc);
      check($sformatf("stream%0d.out_inst", k), bus.out_inst, exp_v ? 32'h100 + exp_pc : NOP);
      check($sformatf("stream%0d.count_le1", k), 32'(bus.count <= 3'd1), 32'd1);
      if (k == 0) begin
        check("stream0.imem_req", 32'(bus.imem_req), 32'd1);
        check("stream0.imem_addr", bus.imem_addr, 32'h0);
      end
      $display("stream %0d: valid=%0b pc=%h inst=%h count=%0d", k, bus.out_valid,
               bus.out_pc, bus.out_inst, bus.count);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
